drlp_cfg_shadow: RTL and testbench

Parametrised, double-buffered configuration register bank for a DRLP processing engine. The host programs a shadow bank while the engine runs from an active bank. A start request commits shadow to active and emits a one-cycle start pulse. Exactly one further job may be queued behind a running one. The block also tracks engine completion in a readable/clearable status register with a wrapping job counter.

---
 rtl/drlp_cfg_shadow.sv | 88 ++++++++
 tb/tb_drlp_cfg_shadow.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/drlp_cfg_shadow.sv
// drlp_cfg_shadow: double-buffered config bank with one-deep job queue and done/err status.
module drlp_cfg_shadow #(
  parameter int DATA_W  = 32,
  parameter int NUM_CFG = 6,
  parameter int ADDR_W  = 3
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [DATA_W-1:0]         i_cfg,
  input  logic [ADDR_W-1:0]         i_addr,
  input  logic                      i_wr_en,
  input  logic                      i_rd_en,
  output logic [DATA_W-1:0]         o_rd_data,
  output logic                      o_rd_valid,
  input  logic                      i_done,
  output logic                      o_start,
  output logic                      o_busy,
  output logic                      o_pending,
  output logic [NUM_CFG*DATA_W-1:0] o_active
);
  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;
  localparam logic [ADDR_W-1:0] A_START = ADDR_W'(NUM_CFG);
  localparam logic [ADDR_W-1:0] A_STAT  = ADDR_W'(NUM_CFG + 1);
  state_t                    state_q, state_d;
  logic [NUM_CFG*DATA_W-1:0] shadow_q, shadow_d, active_q, active_d;
  logic [DATA_W-1:0]         rd_data_q, rd_data_d, status;
  logic [7:0]                cnt_q, cnt_d;
  logic                      done_q, done_d, err_q, err_d, start_q, rd_valid_q;
  logic                      wr_data, start_req, wr_stat, done_ok, commit;
  always_comb begin
    wr_data   = i_wr_en && i_addr < A_START;
    start_req = i_wr_en && i_addr == A_START && i_cfg[0];
    wr_stat   = i_wr_en && i_addr == A_STAT;
    done_ok   = i_done && state_q != IDLE;
    // A done in RUN frees the engine, so a same-cycle start commits straight away.
    commit    = (state_q == IDLE && start_req) || (state_q == PEND && i_done) ||
                (state_q == RUN && i_done && start_req);
    state_d   = state_q == IDLE ? (start_req ? RUN : IDLE) :
                state_q == RUN  ? (i_done ? (start_req ? RUN : IDLE) : (start_req ? PEND : RUN)) :
                (i_done ? RUN : PEND);
    err_d     = (state_q == PEND && (start_req || wr_data)) || (state_q == IDLE && i_done) ||
                (err_q && !(wr_stat && i_cfg[3]));
    done_d    = done_ok || (done_q && !(wr_stat && i_cfg[1]));
    cnt_d     = cnt_q + {7'd0, done_ok};
    active_d  = commit ? shadow_q : active_q;
    status    = '0;
    status[3:0]  = {err_q, state_q == PEND, done_q, state_q != IDLE};
    status[15:8] = cnt_q;
    shadow_d  = shadow_q;
    rd_data_d = i_addr == A_STAT ? status : '0;
    for (int r = 0; r < NUM_CFG; r++) begin
      if (wr_data && state_q != PEND && i_addr == ADDR_W'(r))
        shadow_d[r*DATA_W +: DATA_W] = i_cfg;
      if (i_addr == ADDR_W'(r))
        rd_data_d = shadow_q[r*DATA_W +: DATA_W];
    end
    rd_data_d = i_rd_en ? rd_data_d : rd_data_q;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      active_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= i_rd_en;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      start_q    <= commit;
    end
  end
  assign o_rd_data  = rd_data_q;
  assign o_rd_valid = rd_valid_q;
  assign o_start    = start_q;
  assign o_busy     = state_q != IDLE;
  assign o_pending  = state_q == PEND;
  assign o_active   = active_q;
endmodule

// File: tb/tb_drlp_cfg_shadow.sv
// tb_drlp_cfg_shadow: directed test of drlp_cfg_shadow with a read-data scoreboard.
module tb_drlp_cfg_shadow;
  logic         i_clk = 0, i_rst_n = 0, i_wr_en = 0, i_rd_en = 0, i_done = 0;
  logic [31:0]  i_cfg = 0;
  logic [2:0]   i_addr = 0;
  logic [31:0]  o_rd_data;
  logic         o_rd_valid, o_start, o_busy, o_pending;
  logic [191:0] o_active;
  logic [31:0]  exp_q[$];
  int checks = 0, errors = 0;

  drlp_cfg_shadow dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cfg(i_cfg), .i_addr(i_addr),
    .i_wr_en(i_wr_en), .i_rd_en(i_rd_en), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
    .i_done(i_done), .o_start(o_start), .o_busy(o_busy), .o_pending(o_pending),
    .o_active(o_active)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (o_rd_valid) begin
      if (exp_q.size() == 0) chk("rd_unexpected", 64'(o_rd_valid), 64'd0);
      else chk("rd_data", 64'(o_rd_data), 64'(exp_q.pop_front()));
    end
  end

  task automatic step(input logic wr, input logic rd, input logic [2:0] a,
                      input logic [31:0] d, input logic dn);
    i_wr_en = wr; i_rd_en = rd; i_addr = a; i_cfg = d; i_done = dn;
    @(negedge i_clk);
    i_wr_en = 0; i_rd_en = 0; i_addr = 0; i_cfg = 0; i_done = 0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d); step(1, 0, a, d, 0); endtask
  task automatic rd(input logic [2:0] a, input logic [31:0] e);
    exp_q.push_back(e);
    step(0, 1, a, 0, 0);
  endtask
  task automatic done_p(); step(0, 0, 0, 0, 1); endtask
  task automatic idle(); step(0, 0, 0, 0, 0); endtask

  function automatic logic [31:0] act(input int r);
    return o_active[r*32 +: 32];
  endfunction

  initial begin
    repeat (3) @(negedge i_clk);
    chk("rst_busy", 64'(o_busy), 0);
    chk("rst_pending", 64'(o_pending), 0);
    chk("rst_start", 64'(o_start), 0);
    chk("rst_rd_valid", 64'(o_rd_valid), 0);
    chk("rst_rd_data", 64'(o_rd_data), 0);
    chk("rst_active_or", 64'(|o_active), 0);
    i_rst_n = 1;
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), 0);
      chk("rst_no_start", 64'(o_start), 0);
    end
    // Shadow writes, same-cycle read/write, and a no-op START.
    wr(0, 32'hA5A5_0001);
    wr(5, 32'h1234_5678);
    exp_q.push_back(0);
    step(1, 1, 2, 32'h55, 0);
    rd(2, 32'h55);
    wr(6, 0);
    chk("start0_nop_start", 64'(o_start), 0);
    chk("start0_nop_busy", 64'(o_busy), 0);
    wr(6, 1);
    chk("commit1_start", 64'(o_start), 1);
    chk("commit1_busy", 64'(o_busy), 1);
    chk("commit1_r0", 64'(act(0)), 64'hA5A5_0001);
    chk("commit1_r5", 64'(act(5)), 64'h1234_5678);
    chk("commit1_r2", 64'(act(2)), 64'h55);
    rd(7, 32'h1);
    chk("commit1_pulse_end", 64'(o_start), 0);
    // Queue a job, then try to write the frozen shadow.
    wr(0, 32'h11);
    wr(6, 1);
    chk("queue_pending", 64'(o_pending), 1);
    chk("queue_no_start", 64'(o_start), 0);
    chk("queue_active_hold", 64'(act(0)), 64'hA5A5_0001);
    wr(0, 32'h22);
    rd(7, 32'hD);
    done_p();
    chk("pend_done_start", 64'(o_start), 1);
    chk("pend_done_r0", 64'(act(0)), 64'h11);
    chk("pend_done_pending", 64'(o_pending), 0);
    chk("pend_done_busy", 64'(o_busy), 1);
    rd(7, 32'h10B);
    rd(0, 32'h11);
    wr(7, 32'hA);
    rd(7, 32'h101);
    // Same-cycle done and start while in RUN.
    wr(1, 32'h77);
    step(1, 0, 6, 1, 1);
    chk("run_done_start_pulse", 64'(o_start), 1);
    chk("run_done_start_busy", 64'(o_busy), 1);
    chk("run_done_start_pend", 64'(o_pending), 0);
    chk("run_done_start_r1", 64'(act(1)), 64'h77);
    rd(7, 32'h203);
    // W1C coinciding with a done: set wins.
    step(1, 0, 7, 32'hA, 1);
    chk("w1c_done_busy", 64'(o_busy), 0);
    rd(7, 32'h302);
    done_p();
    chk("idle_done_no_start", 64'(o_start), 0);
    rd(7, 32'h30A);
    wr(7, 32'hA);
    rd(7, 32'h300);
    // Remaining jobs bring the done count to 256, wrapping to 0.
    for (int j = 0; j < 253; j++) begin
      wr(6, 1);
      chk("wrap_start", 64'(o_start), 1);
      done_p();
    end
    rd(7, 32'h2);
    // Back-to-back commit, then reset while PEND.
    wr(6, 1);
    wr(6, 1);
    done_p();
    chk("b2b_start", 64'(o_start), 1);
    wr(6, 1);
    chk("b2b_pending", 64'(o_pending), 1);
    i_rst_n = 0;
    step(0, 1, 0, 0, 1);
    chk("rst_pend_busy", 64'(o_busy), 0);
    chk("rst_pend_pending", 64'(o_pending), 0);
    chk("rst_pend_start", 64'(o_start), 0);
    chk("rst_pend_active", 64'(|o_active), 0);
    chk("rst_pend_rd_valid", 64'(o_rd_valid), 0);
    i_rst_n = 1;
    idle();
    chk("post_rst_start", 64'(o_start), 0);
    rd(0, 0);
    rd(7, 0);
    idle();
    chk("queue_drained", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
